// File: rtl/xintf_dpbram_slave_if.sv
// DSP XINTF zone bus as seen by the fabric: async strobes, address, and a split
// data bus with a pad output enable.
interface xintf_dpbram_slave_if #(
  parameter int ADDR_W = 10
);
  logic              zcs_n;
  logic              rd_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wr_data;
  logic [15:0]       rd_data;
  logic              rd_data_oe;

  modport master (output zcs_n, rd_n, we_n, addr, wr_data, input rd_data, rd_data_oe);
  modport slave  (input zcs_n, rd_n, we_n, addr, wr_data, output rd_data, rd_data_oe);
endinterface

// File: rtl/xintf_dpbram_slave.sv
// DSP-side XINTF slave: reads from the Zynq-to-DSP DPBRAM, writes to the DSP-to-Zynq DPBRAM.
// Optional XINTF_DOORBELL_EN: a write to DOORBELL_ADDR in region 1 also pulses o_frame_done.
module xintf_dpbram_slave #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         ADDR_W        = 10,
  parameter int         RD_LAT        = 2,
  parameter logic [8:0] DOORBELL_ADDR = 9'h1FF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  xintf_dpbram_slave_if.slave   bus,
  output logic [8:0]            o_z_to_d_addr,
  output logic                  o_z_to_d_ce,
  input  logic [15:0]           i_z_to_d_dout,
  output logic [8:0]            o_d_to_z_addr,
  output logic                  o_d_to_z_ce,
  output logic                  o_d_to_z_we,
  output logic [15:0]           o_d_to_z_din,
  output logic                  o_rd_done,
  output logic                  o_wr_done,
  output logic                  o_err,
  output logic                  o_frame_done
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_DRIVE, WR_COMMIT, WR_RELEASE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] zcs_sync, rd_sync, we_sync;
  logic                   rd_act, wr_act, rd_act_q, wr_act_q, rd_rise, wr_rise;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d, rd_data_q;
  logic [2:0]             cnt;
  logic                   err_set, oe_q, db_hit;

  // Strobes idle high, so the chains preset to 1 to avoid a false start after reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      zcs_sync <= '1;
      rd_sync  <= '1;
      we_sync  <= '1;
      rd_act_q <= 1'b0;
      wr_act_q <= 1'b0;
    end else begin
      zcs_sync <= {zcs_sync[SYNC_STAGES-2:0], bus.zcs_n};
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0],  bus.rd_n};
      we_sync  <= {we_sync[SYNC_STAGES-2:0],  bus.we_n};
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
    end
  end

  assign rd_act  = ~zcs_sync[SYNC_STAGES-1] & ~rd_sync[SYNC_STAGES-1];
  assign wr_act  = ~zcs_sync[SYNC_STAGES-1] & ~we_sync[SYNC_STAGES-1];
  assign rd_rise = rd_act & ~rd_act_q;
  assign wr_rise = wr_act & ~wr_act_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_rise) begin
          state_nx = RD_ISSUE;
          addr_d   = bus.addr;
          err_set  = wr_rise;
        end else if (wr_rise) begin
          state_nx = WR_COMMIT;
          addr_d   = bus.addr;
          wdata_d  = bus.wr_data;
        end
      end
      RD_ISSUE: begin
        if (addr_q[ADDR_W-1]) begin
          err_set  = 1'b1;
          state_nx = RD_DRIVE;
        end else begin
          state_nx = RD_WAIT;
        end
      end
      RD_WAIT:    if (cnt == 3'(RD_LAT-1)) state_nx = RD_DRIVE;
      RD_DRIVE:   if (!rd_act) state_nx = IDLE;
      WR_COMMIT: begin
        err_set  = ~addr_q[ADDR_W-1];
        state_nx = WR_RELEASE;
      end
      WR_RELEASE: if (!wr_act) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

`ifdef XINTF_DOORBELL_EN
  assign db_hit = (addr_d[8:0] == DOORBELL_ADDR);
`else
  logic unused_db;
  assign unused_db = ^DOORBELL_ADDR;
  assign db_hit    = 1'b0;
`endif

  // Strobe-type outputs are registered from the next state so each is high
  // for exactly the one cycle the FSM spends in the matching state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      cnt          <= '0;
      oe_q         <= 1'b0;
      o_z_to_d_ce  <= 1'b0;
      o_d_to_z_ce  <= 1'b0;
      o_d_to_z_we  <= 1'b0;
      o_rd_done    <= 1'b0;
      o_wr_done    <= 1'b0;
      o_err        <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt          <= (state == RD_WAIT) ? cnt + 3'd1 : 3'd0;
      oe_q         <= (state_nx == RD_DRIVE);
      o_z_to_d_ce  <= (state_nx == RD_ISSUE)  & ~addr_d[ADDR_W-1];
      o_d_to_z_ce  <= (state_nx == WR_COMMIT) &  addr_d[ADDR_W-1];
      o_d_to_z_we  <= (state_nx == WR_COMMIT) &  addr_d[ADDR_W-1];
      o_wr_done    <= (state_nx == WR_COMMIT) &  addr_d[ADDR_W-1];
      o_frame_done <= (state_nx == WR_COMMIT) &  addr_d[ADDR_W-1] & db_hit;
      o_rd_done    <= (state == RD_DRIVE) & (state_nx == IDLE);
      o_err        <= o_err | err_set;
      if (state == RD_ISSUE && addr_q[ADDR_W-1])
        rd_data_q <= 16'h0000;
      else if (state == RD_WAIT && state_nx == RD_DRIVE)
        rd_data_q <= i_z_to_d_dout;
    end
  end

  assign o_z_to_d_addr  = addr_q[8:0];
  assign o_d_to_z_addr  = addr_q[8:0];
  assign o_d_to_z_din   = wdata_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_data_oe = oe_q;

endmodule

// File: tb/tb_xintf_dpbram_slave.sv
// Directed + randomized bench for xintf_dpbram_slave with a transaction-level reference model.
`timescale 1ns/1ps
module tb_xintf_dpbram_slave;

`ifdef XINTF_DOORBELL_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [8:0]  z_addr, d_addr;
  logic        z_ce, d_ce, d_we;
  logic [15:0] z_dout, d_din;
  logic        rd_done, wr_done, err, frame_done;

  xintf_dpbram_slave_if #(.ADDR_W(10)) xif ();

  xintf_dpbram_slave dut (
    .i_clk(clk), .i_rst(rst), .bus(xif),
    .o_z_to_d_addr(z_addr), .o_z_to_d_ce(z_ce), .i_z_to_d_dout(z_dout),
    .o_d_to_z_addr(d_addr), .o_d_to_z_ce(d_ce), .o_d_to_z_we(d_we), .o_d_to_z_din(d_din),
    .o_rd_done(rd_done), .o_wr_done(wr_done), .o_err(err), .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Z-to-D BRAM model, 2-cycle read latency
  logic [15:0] zmem [512];
  logic [15:0] r1, r2;
  always @(posedge clk) begin
    if (z_ce) r1 <= zmem[z_addr];
    r2 <= r1;
  end
  assign z_dout = r2;

  // Event monitor, sampled just after each active edge
  int zce_cnt = 0, we_cnt = 0, rdd_cnt = 0, wrd_cnt = 0, fd_cnt = 0, fd_orphan = 0;
  logic [8:0]  zce_addr, we_addr;
  logic [15:0] we_din;
  always @(posedge clk) begin
    #1;
    if (z_ce) begin zce_cnt <= zce_cnt + 1; zce_addr <= z_addr; end
    if (d_ce && d_we) begin we_cnt <= we_cnt + 1; we_addr <= d_addr; we_din <= d_din; end
    if (rd_done) rdd_cnt <= rdd_cnt + 1;
    if (wr_done) wrd_cnt <= wrd_cnt + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (frame_done && !wr_done) fd_orphan <= fd_orphan + 1;
  end

  int n_chk = 0, n_fail = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dsp_read(input logic [9:0] a, input bit also_we, input bit end_by_cs);
    logic [15:0] exp_d;
    int n, ce0, rd0, we0;
    exp_d = a[9] ? 16'h0000 : zmem[a[8:0]];
    if (a[9] || also_we) err_exp = 1'b1;
    ce0 = zce_cnt; rd0 = rdd_cnt; we0 = we_cnt;
    @(negedge clk);
    xif.addr = a; xif.zcs_n = 1'b0; xif.rd_n = 1'b0;
    if (also_we) xif.we_n = 1'b0;
    n = 0;
    while (xif.rd_data_oe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rd_latency", 64'(n), a[9] ? 64'd4 : 64'd6);
    chk("rd_data", {xif.rd_data_oe, xif.rd_data}, {1'b1, exp_d});
    chk("rd_err", err, err_exp);
    chk("rd_ce_cnt", 64'(zce_cnt - ce0), a[9] ? 64'd0 : 64'd1);
    if (!a[9]) chk("rd_ce_addr", zce_addr, a[8:0]);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("rd_hold", {xif.rd_data_oe, xif.rd_data}, {1'b1, exp_d});
    if (end_by_cs) xif.zcs_n = 1'b1; else xif.rd_n = 1'b1;
    n = 0;
    while (xif.rd_data_oe !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("rd_release_oe", xif.rd_data_oe, 1'b0);
    chk("rd_done_cnt", 64'(rdd_cnt - rd0), 64'd1);
    chk("rd_no_we", 64'(we_cnt - we0), 64'd0);
    xif.zcs_n = 1'b1; xif.rd_n = 1'b1; xif.we_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic dsp_write(input logic [9:0] a, input logic [15:0] d, input int width);
    int we0, wd0, fd0;
    bit commit;
    commit = a[9];
    if (!commit) err_exp = 1'b1;
    we0 = we_cnt; wd0 = wrd_cnt; fd0 = fd_cnt;
    @(negedge clk);
    xif.addr = a; xif.wr_data = d; xif.zcs_n = 1'b0; xif.we_n = 1'b0;
    repeat (width) @(negedge clk);
    xif.zcs_n = 1'b1; xif.we_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("wr_we_cnt", 64'(we_cnt - we0), 64'(commit));
    chk("wr_done_cnt", 64'(wrd_cnt - wd0), 64'(commit));
    chk("wr_frame_cnt", 64'(fd_cnt - fd0), 64'(commit && DB_EN && a[8:0] == 9'h1FF));
    chk("wr_err", err, err_exp);
    if (commit) chk("wr_addr_din", {we_addr, we_din}, {a[8:0], d});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) zmem[i] = 16'($urandom);
    zmem[5] = 16'h1234;
    rst = 1'b1;
    xif.zcs_n = 1'b0; xif.rd_n = 1'b0; xif.we_n = 1'b0;
    xif.addr = '0; xif.wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {xif.rd_data, xif.rd_data_oe, z_addr, z_ce, d_addr, d_ce, d_we, d_din,
                       rd_done, wr_done, err, frame_done}, 64'd0);
    xif.zcs_n = 1'b1; xif.rd_n = 1'b1; xif.we_n = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    dsp_read(10'h005, 1'b0, 1'b0);
    dsp_write(10'h203, 16'hBEEF, 20);
    dsp_write(10'h010, 16'h5A5A, 5);
    dsp_read(10'h210, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [9:0] a;
      a = 10'($urandom);
      if ($urandom_range(0, 1) == 0) dsp_read(a, 1'b0, 1'($urandom_range(0, 1)));
      else dsp_write(a, 16'($urandom), $urandom_range(3, 12));
    end

    dsp_read(10'h07A, 1'b1, 1'b0);

    // Reset while the read data is being driven
    @(negedge clk);
    xif.addr = 10'h005; xif.zcs_n = 1'b0; xif.rd_n = 1'b0;
    n = 0;
    while (xif.rd_data_oe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("mid_rd_drive", {xif.rd_data_oe, xif.rd_data}, {1'b1, 16'h1234});
    n = rdd_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rd_oe", {xif.rd_data_oe, err}, 2'b00);
    xif.zcs_n = 1'b1; xif.rd_n = 1'b1;
    @(negedge clk); rst = 1'b0; err_exp = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rd_no_done", 64'(rdd_cnt - n), 64'd0);
    dsp_read(10'h005, 1'b0, 1'b0);

    // Reset just before the write would commit
    n = we_cnt;
    @(negedge clk);
    xif.addr = 10'h2AA; xif.wr_data = 16'hC0DE; xif.zcs_n = 1'b0; xif.we_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xif.zcs_n = 1'b1; xif.we_n = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_wr_discard", 64'(we_cnt - n), 64'd0);

    dsp_write(10'h3FF, 16'h0001, 4);
    dsp_write(10'h3FE, 16'h0002, 4);
    chk("frame_orphan", 64'(fd_orphan), 64'd0);
    chk("final_err", err, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
